// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package alu_arb_pkg;

   localparam int STATS_W   = 16;
   // Widest tag ever needed (REQ <= 16).
   localparam int TAG_MAX_W = 4;

   // Ceiling log2, used to size the requester index / tag.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // One in-flight tracking stage.
   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
   } stage_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
   parameter int REQ   = 4,
   parameter int IDX_W = 2
) (
   input  logic [REQ-1:0]   req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [REQ-1:0]   gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int unsigned k;

   // Scan from ptr_i upward modulo REQ and take the first active request.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < REQ; i++) begin
         k = (32'(ptr_i) + i) % REQ;
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external registered adder among REQ requesters.
// A valid/tag pipeline of LAT stages routes each result back to its issuer.
// Optional: define ADDER_ARB_STATS_EN for per-requester saturating grant counters.
module adder_rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N   = 32,
   parameter int REQ = 4,
   parameter int LAT = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic [REQ-1:0]     req_valid_i,
   input  logic [REQ*N-1:0]   req_a_i,
   input  logic [REQ*N-1:0]   req_b_i,
   input  logic [REQ-1:0]     req_c_i,
   output logic [REQ-1:0]     req_ready_o,
   output logic [N-1:0]       add_a_o,
   output logic [N-1:0]       add_b_o,
   output logic               add_c_o,
   input  logic [N-1:0]       add_s_i,
   input  logic               add_c_i,
   output logic [REQ-1:0]     rsp_valid_o,
   output logic [N-1:0]       rsp_s_o,
   output logic               rsp_c_o,
`ifdef ADDER_ARB_STATS_EN
   input  logic               stats_clr_i,
   output logic [REQ*STATS_W-1:0] stats_o,
`endif
   output logic               idle_o
);

   localparam int TAG_W = clog2(REQ);

   logic [TAG_W-1:0] ptr_q, ptr_d;
   logic [REQ-1:0]   pick_gnt;
   logic [TAG_W-1:0] pick_idx;
   logic             pick_any;
   logic             issue_ok;
   logic             xfer;
   stage_t           stage_q [LAT];

   rr_pick #(
      .REQ   (REQ),
      .IDX_W (TAG_W)
   ) u_pick (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign issue_ok    = en_i & rst_ni;
   assign xfer        = issue_ok & pick_any;
   assign req_ready_o = issue_ok ? pick_gnt : '0;

   assign rsp_s_o = add_s_i;
   assign rsp_c_o = add_c_i;

   // Route the granted requester's operands to the adder; zero when idle.
   always_comb begin
      add_a_o = '0;
      add_b_o = '0;
      add_c_o = 1'b0;
      if (xfer) begin
         add_a_o = req_a_i[32'(pick_idx)*N +: N];
         add_b_o = req_b_i[32'(pick_idx)*N +: N];
         add_c_o = req_c_i[pick_idx];
      end
   end

   // Next pointer: one past the granted requester, wrapping at REQ.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (pick_idx == TAG_W'(REQ - 1)) ? '0 : pick_idx + TAG_W'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   // Valid/tag shift pipeline tracking operations inside the adder.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= '{valid: xfer, tag: TAG_MAX_W'(pick_idx)};
         for (int unsigned i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   // Response strobe decoded from the last stage; suppressed during reset so
   // discarded operations are never reported.
   always_comb begin
      rsp_valid_o = '0;
      for (int unsigned i = 0; i < REQ; i++) begin
         rsp_valid_o[i] = rst_ni && stage_q[LAT-1].valid &&
                          (stage_q[LAT-1].tag == TAG_MAX_W'(i));
      end
   end

   // Idle when no stage holds a valid operation.
   always_comb begin
      idle_o = 1'b1;
      for (int unsigned i = 0; i < LAT; i++) begin
         if (stage_q[i].valid) idle_o = 1'b0;
      end
   end

`ifdef ADDER_ARB_STATS_EN
   logic [STATS_W-1:0] cnt_q [REQ];

   // Per-requester saturating grant counters; clear beats increment.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || stats_clr_i) begin
         for (int unsigned i = 0; i < REQ; i++) cnt_q[i] <= '0;
      end else if (xfer && (cnt_q[pick_idx] != '1)) begin
         cnt_q[pick_idx] <= cnt_q[pick_idx] + STATS_W'(1);
      end
   end

   // Flatten counters onto the stats bus.
   always_comb begin
      stats_o = '0;
      for (int unsigned i = 0; i < REQ; i++) stats_o[i*STATS_W +: STATS_W] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter with a behavioural 2-stage adder.
module tb_adder_rr_arbiter;

   localparam int N   = 32;
   localparam int REQ = 4;
   localparam int LAT = 2;

   typedef struct packed {
      logic [3:0] tag;
      logic [N:0] sum;
      int         due;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [REQ-1:0]   vld;
   logic [REQ-1:0]   c_in;
   logic [N-1:0]     opa [REQ];
   logic [N-1:0]     opb [REQ];
   logic [REQ*N-1:0] a_pk, b_pk;

   logic [REQ-1:0]   req_ready;
   logic [N-1:0]     add_a, add_b, add_s;
   logic             add_c, add_co;
   logic [REQ-1:0]   rsp_valid;
   logic [N-1:0]     rsp_s;
   logic             rsp_c;
   logic             idle;
`ifdef ADDER_ARB_STATS_EN
   logic             stats_clr;
   logic [REQ*16-1:0] stats;
`endif

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   mon_on = 1'b0;
   int   mptr  = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < REQ; i++) begin
         a_pk[i*N +: N] = opa[i];
         b_pk[i*N +: N] = opb[i];
      end
   end

   // Behavioural shared adder: operand registers, then result registers.
   logic [N-1:0] ra, rb;
   logic         rc;
   always @(posedge clk) begin
      ra <= add_a;
      rb <= add_b;
      rc <= add_c;
      {add_co, add_s} <= {1'b0, ra} + {1'b0, rb} + (N+1)'(rc);
   end

   adder_rr_arbiter #(.N(N), .REQ(REQ), .LAT(LAT)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .req_valid_i (vld),
      .req_a_i     (a_pk),
      .req_b_i     (b_pk),
      .req_c_i     (c_in),
      .req_ready_o (req_ready),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_c_o     (add_c),
      .add_s_i     (add_s),
      .add_c_i     (add_co),
      .rsp_valid_o (rsp_valid),
      .rsp_s_o     (rsp_s),
      .rsp_c_o     (rsp_c),
`ifdef ADDER_ARB_STATS_EN
      .stats_clr_i (stats_clr),
      .stats_o     (stats),
`endif
      .idle_o      (idle)
   );

   // Scoreboard monitor: models the grant pointer, pushes expected results at
   // issue and pops them when the response is due.
   logic [REQ-1:0] m_eg, m_rsp;
   logic           m_idle, m_found;
   exp_t           m_e;
   int             m_idx, m_g;
   always @(negedge clk) begin
      if (mon_on) begin
         m_idle = (q.size() == 0);
         m_rsp  = '0;
         m_e    = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            m_e = q.pop_front();
            if (rst_n) m_rsp = REQ'(1) << m_e.tag;
         end
         n_cmp++;
         if (rsp_valid !== m_rsp) begin
            n_err++;
            $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_rsp);
         end
         if (m_rsp != '0) begin
            n_cmp++;
            if ({rsp_c, rsp_s} !== m_e.sum) begin
               n_err++;
               $display("FAIL sb_sum cyc=%0d got=%h exp=%h", cyc, {rsp_c, rsp_s}, m_e.sum);
            end
         end
         n_cmp++;
         if (idle !== m_idle) begin
            n_err++;
            $display("FAIL sb_idle cyc=%0d got=%b exp=%b", cyc, idle, m_idle);
         end
         m_eg = '0;
         m_found = 1'b0;
         m_g = 0;
         if (rst_n && en) begin
            for (int k = 0; k < REQ; k++) begin
               m_idx = (mptr + k) % REQ;
               if (!m_found && vld[m_idx]) begin
                  m_found = 1'b1;
                  m_g = m_idx;
                  m_eg[m_idx] = 1'b1;
               end
            end
         end
         n_cmp++;
         if (req_ready !== m_eg) begin
            n_err++;
            $display("FAIL sb_grant cyc=%0d got=%b exp=%b", cyc, req_ready, m_eg);
         end
         if (m_found) begin
            q.push_back('{tag: 4'(m_g),
                          sum: {1'b0, opa[m_g]} + {1'b0, opb[m_g]} + (N+1)'(c_in[m_g]),
                          due: cyc + LAT});
            mptr = (m_g + 1) % REQ;
         end
         if (!rst_n) begin
            q.delete();
            mptr = 0;
         end
      end
   end

   task automatic randomize_ops(input logic [REQ-1:0] which);
      for (int i = 0; i < REQ; i++) begin
         if (which[i]) begin
            opa[i]  = $urandom;
            opb[i]  = $urandom;
            c_in[i] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic drain(input int n);
      vld = '0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      vld = '1;
      en  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if (req_ready !== '0) begin
            n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
         end
         n_cmp++;
         if (idle !== 1'b1) begin
            n_err++; $display("FAIL reset_idle got=%b exp=1", idle);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
      end
      @(posedge clk); #1;
      drain(3);
   endtask

   task automatic test_single();
      logic [REQ-1:0] g;
      vld = 4'b0010;
      opa[1] = 32'hFFFF_FFFF; opb[1] = 32'h0000_0001; c_in[1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0010) begin
         n_err++; $display("FAIL single_grant got=%b exp=0010", req_ready);
      end
      @(posedge clk); #1;
      vld = '0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 4'b0010 || rsp_s !== 32'h0 || rsp_c !== 1'b1) begin
         n_err++;
         $display("FAIL single_rsp got=%b/%h/%b exp=0010/00000000/1", rsp_valid, rsp_s, rsp_c);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (idle !== 1'b1) begin
         n_err++; $display("FAIL single_idle got=%b exp=1", idle);
      end
      // Lone requester is granted back to back.
      @(posedge clk); #1;
      vld = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         g = req_ready;
         n_cmp++;
         if (g !== 4'b0010) begin
            n_err++; $display("FAIL single_b2b k=%0d got=%b exp=0010", k, g);
         end
         @(posedge clk); #1;
         randomize_ops(g);
      end
      drain(3);
   endtask

   task automatic test_contention();
      logic [REQ-1:0] g;
      pulse_reset();
      vld = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         g = req_ready;
         n_cmp++;
         if (g !== (REQ'(1) << (k % REQ))) begin
            n_err++;
            $display("FAIL contention_rot k=%0d got=%b exp=%b", k, g, REQ'(1) << (k % REQ));
         end
         @(posedge clk); #1;
         randomize_ops(g);
      end
      drain(3);
   endtask

   task automatic test_en_drop();
      logic [REQ-1:0] g;
      vld = 4'b1001;
      en  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         g = req_ready;
         @(posedge clk); #1;
         randomize_ops(g);
      end
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (req_ready !== '0) begin
            n_err++; $display("FAIL endrop_ready k=%0d got=%b exp=0000", k, req_ready);
         end
         n_cmp++;
         if (idle !== (k >= 2)) begin
            n_err++; $display("FAIL endrop_idle k=%0d got=%b exp=%b", k, idle, k >= 2);
         end
         @(posedge clk); #1;
      end
      en = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL endrop_ptr_hold got=%b exp=0001", req_ready);
      end
      @(posedge clk); #1;
      drain(3);
   endtask

   task automatic test_reset_midflight();
      logic [REQ-1:0] g;
      vld = 4'b0110;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         g = req_ready;
         @(posedge clk); #1;
         randomize_ops(g);
      end
      rst_n = 1'b0;
      vld   = '1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== '0 || req_ready !== '0) begin
         n_err++;
         $display("FAIL midrst_during got=%b/%b exp=0000/0000", rsp_valid, req_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== '0 || req_ready !== 4'b0001 || idle !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_after got=%b/%b/%b exp=0000/0001/1", rsp_valid, req_ready, idle);
      end
      @(posedge clk); #1;
      drain(4);
   endtask

`ifdef ADDER_ARB_STATS_EN
   task automatic test_stats();
      logic [15:0] c2;
      pulse_reset();
      vld = 4'b0100;
      for (int k = 0; k <= 70000; k++) begin
         @(negedge clk);
         c2 = stats[2*16 +: 16];
         if (k == 5 || k == 70000) begin
            n_cmp++;
            if (c2 !== ((k > 65535) ? 16'hFFFF : 16'(k))) begin
               n_err++; $display("FAIL stats_count k=%0d got=%h", k, c2);
            end
         end
         @(posedge clk); #1;
      end
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (stats !== '0) begin
         n_err++; $display("FAIL stats_clear got=%h exp=0", stats);
      end
      @(posedge clk); #1;
      drain(3);
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      vld   = '0;
      c_in  = '0;
      for (int i = 0; i < REQ; i++) begin
         opa[i] = $urandom;
         opb[i] = $urandom;
      end
`ifdef ADDER_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      @(posedge clk); #1;
      mon_on = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_en_drop();
      test_reset_midflight();
`ifdef ADDER_ARB_STATS_EN
      test_stats();
`endif
      n_cmp++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover got=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered N-bit adder (2-edge latency: input registers, then output registers) among REQ requesters.
- Issues at most one add per cycle.
- Tracks in-flight operations with a valid/tag shift pipeline matched to the adder latency.
- Returns each sum and carry to the requester that issued it.
- Sits between ALU-side requesters and the shared adder instance; the adder itself is instantiated outside this block.

Parameters:
- N, 32, operand and sum width.
- REQ, 4, number of requesters (2..16).
- LAT, 2, adder latency in clock edges from operand capture to registered result (must be at least 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous reset, active-low.
- en_i  in  1  issue enable; when low, no new grants are made and in-flight operations drain.
- req_valid_i  in  REQ  per-requester request valid.
- req_a_i  in  REQ*N  operand A, requester i at bits [i*N +: N].
- req_b_i  in  REQ*N  operand B, packed the same way.
- req_c_i  in  REQ  carry-in per requester.
- req_ready_o  out  REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- add_a_o  out  N  to adder a_i.
- add_b_o  out  N  to adder b_i.
- add_c_o  out  1  to adder c_i.
- add_s_i  in  N  from adder sr_o.
- add_c_i  in  1  from adder cr_o.
- rsp_valid_o  out  REQ  one-hot response strobe, high for exactly one cycle per accepted request.
- rsp_s_o  out  N  sum (pass-through of add_s_i).
- rsp_c_o  out  1  carry (pass-through of add_c_i).
- idle_o  out  1  high when no operation is in flight.

Behaviour:
- Grant (combinational):
  - Scan starts at requester ptr and wraps modulo REQ.
  - The first requester with req_valid_i high receives req_ready_o, gated by en_i.
  - req_ready_o may depend on req_valid_i.
  - Requesters must hold a, b and c stable while valid is high and ready is low.
- Operand mux: add_a_o, add_b_o and add_c_o carry the granted requester's operands. With no grant they are all-zero.
- Pointer update:
  - On each accepted transfer to requester g, ptr becomes (g+1) mod REQ.
  - ptr is unchanged on cycles with no transfer.
  - Reset value of ptr is 0.
- Tag pipeline:
  - LAT stages, each holding one valid bit and one tag of clog2(REQ) bits, advancing every cycle.
  - Stage 0 loads (transfer, g).
  - rsp_valid_o is one-hot of the stage LAT-1 tag, qualified by the stage LAT-1 valid bit.
- Latency: a request accepted in cycle t produces rsp_valid_o in cycle t+LAT. Throughput is 1 per cycle. There is no response backpressure; requesters must always sink responses.
- idle_o is the NOR of all stage valid bits.
- en_i low: req_ready_o is all-zero, ptr holds, and the pipeline keeps draining, so idle_o rises LAT cycles after the last issue.
- Boundaries:
  - Single active requester: it is granted every cycle.
  - All requesters active: grants rotate 0,1,2,3,0,...
  - A requester already in flight may be granted again; responses return in issue order.
  - Same-cycle issue and response for different or identical requesters are both legal.
- Reset:
  - Takes effect at the clock edge with rst_ni low.
  - ptr goes to 0, all stage valid bits clear, and rsp_valid_o is 0 from the next cycle.
  - In-flight operations are discarded and never reported.
  - idle_o is 1 after reset.
  - req_ready_o is forced to 0 while rst_ni is low.
- Outputs after reset: req_ready_o follows inputs; rsp_valid_o = 0; add_* = 0 when nothing is granted; idle_o = 1.

Optional Feature:
- Macro ADDER_ARB_STATS_EN.
- Defined:
  - Adds output stats_o, REQ*16 bits.
  - Holds one 16-bit saturating grant counter per requester: it increments on each accepted transfer and holds at 0xFFFF.
  - Counters clear on reset.
  - Adds input stats_clr_i (1 bit). When high, all counters clear that cycle, taking priority over the increment.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package alu_arb_pkg:
  - tag width function clog2 for tag width.
  - STATS_W = 16.
  - Typedef for the pipeline stage struct {valid, tag}.
- Sub-module rr_pick: combinational round-robin priority picker with inputs (req vector, ptr) and outputs (one-hot grant, encoded index, any).

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with all valid high -> req_ready_o=0, idle_o=1. First grant after release goes to req0.
- Single requester: req1 issues A=0xFFFFFFFF, B=0x00000001, c=0 -> rsp_valid_o=0010 two cycles later with sum 0x00000000 and carry 1. idle_o returns to 1.
- Full contention: all 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each response tag matches its issue order, delayed by 2 cycles.
- en_i drop: with 2 operations in flight, drive en_i=0 -> no new ready. Both responses arrive, then idle_o=1 after 2 cycles.
- Reset mid-flight: issue 2 operations, then assert rst_ni low in the next cycle -> no rsp_valid_o ever fires for them, and ptr=0.
- ADDER_ARB_STATS_EN: 70000 grants to req2 -> counter saturates at 0xFFFF. stats_clr_i=1 clears it to 0.
